decide_backtrack_ctrl: RTL
==========================

# decide_backtrack_ctrl

DPLL sequencing controller for the SAT solver core. Owns the assignment trail and the decision level, picks the next decision variable, hands each assignment to the BCP unit, and on conflict performs chronological backtracking. It signals `sat` or `unsat` when the search ends. It sits under `control`, between the start/result interface and the BCP/variable-state datapath.

## Interface
- `NUM_VARIABLE`, 128: number of solver variables; each is assigned at most once on the trail.
- `VARIABLE_INDEX`, 6: MSB of a variable index; index width is VARIABLE_INDEX+1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  one-cycle pulse; starts a solve; honoured only in IDLE, SAT_DONE or UNSAT_DONE.
- `bcp_req`  out  1  one-cycle pulse; `bcp_var`/`bcp_val` hold a new assignment to propagate.
- `bcp_var`  out  VARIABLE_INDEX+1  variable of the current request; held until the next request.
- `bcp_val`  out  1  value of the current request.
- `imp_valid`  in  1  BCP reports an implied assignment.
- `imp_var`  in  VARIABLE_INDEX+1  implied variable.
- `imp_val`  in  1  implied value.
- `bcp_done`  in  1  pulse; propagation of the last request has finished.
- `bcp_conflict`  in  1  qualified by `bcp_done`; 1 means a conflict was found.
- `unassign_valid`  out  1  pulse; `unassign_var` was popped from the trail and must be cleared.
- `unassign_var`  out  VARIABLE_INDEX+1  variable being cleared.
- `level`  out  VARIABLE_INDEX+2  current decision level (0..NUM_VARIABLE).
- `busy`  out  1  high in every state except IDLE, SAT_DONE and UNSAT_DONE.
- `sat`, `unsat`  out  1  result flags, held until the next `start` or reset.

## Operation
- Trail: a stack of NUM_VARIABLE entries {var, val, is_decision, flipped}.
- Pointer `tp` has width VARIABLE_INDEX+2 and ranges 0..NUM_VARIABLE.
- The `assigned` bit-vector has NUM_VARIABLE bits.
- States:
  - IDLE: on `start`, clear `assigned`, set `tp`=0, `level`=0, drop `sat`/`unsat`, then go to DECIDE.
  - DECIDE: if all variables are assigned, go to SAT_DONE. Otherwise take the lowest unassigned index v, push {v,0,1,0}, set assigned[v], increment `level`, load bcp_var=v and bcp_val=0, then go to PROPAGATE.
  - PROPAGATE: `bcp_req` is high in the first cycle only.
    - Each `imp_valid` pushes {imp_var,imp_val,0,0} and sets the assigned bit.
    - An implication for an already-assigned variable is dropped.
    - On `bcp_done`: no conflict goes to DECIDE; conflict goes to BACKTRACK.
  - BACKTRACK: one action per cycle on the top entry (tp-1).
    - If tp==0, go to UNSAT_DONE.
    - If the entry is an implication or a flipped decision: pop it, clear its assigned bit, pulse `unassign_valid`/`unassign_var`; decrement `level` if it was a decision.
    - If the entry is an unflipped decision: invert its val, set flipped=1, keep it assigned, load bcp_var/bcp_val with the new value, keep `level` unchanged, and go to PROPAGATE.
  - SAT_DONE / UNSAT_DONE: `sat` or `unsat` stays high. `start` restarts the search exactly as in IDLE.
- `start` in any other state is ignored.
- If `imp_valid` and `bcp_done` occur in the same cycle, the implication is pushed first. With a conflict, it is later popped like any other implication.
- `imp_valid`/`bcp_done` outside PROPAGATE are ignored.
- The trail cannot overflow because duplicate implications are dropped.

## Timing
- Reset (async): state IDLE, `tp`=0, `assigned`=0. All outputs are 0: `bcp_req`, `bcp_var`, `bcp_val`, `unassign_valid`, `unassign_var`, `level`, `busy`, `sat`, `unsat`.
- `start` to first `bcp_req`: 2 cycles (IDLE→DECIDE→PROPAGATE).
- `bcp_done` without conflict to next `bcp_req`: 2 cycles. With all variables assigned, `sat` rises 2 cycles after `bcp_done`.
- Backtrack: one pop per cycle. The flip's `bcp_req` comes 1 cycle after the flip cycle.
- From UNSAT detection (tp==0 in BACKTRACK), `unsat` rises the next cycle.
- Trail push from `imp_valid` is visible in `tp` the following cycle.

## Structure
- Package `sat_pkg`: `VAR_W`, `trail_entry_t` struct, and the `ctrl_state_t` enum. The package is shared with `control` and the BCP unit.
- Sub-module `unassigned_finder`: a combinational lowest-zero priority encoder over `assigned`, giving `found` and `index`.
- The trail is a register array inside this block.

## Test plan
- Reset: drive `reset`=0 mid-PROPAGATE → state IDLE and all outputs 0 immediately; `start` after release works normally.
- NUM_VARIABLE=4 with a BCP model that never conflicts or implies: `start` → 4 requests (var 0..3, val 0), `level`=4, then `sat`=1 and `busy`=0.
- After decision v0=0, BCP implies v2=1 → next decision is v1 (v2 skipped), `tp`=3.
- Conflict on decision v1=0 with implication v3 pushed → `unassign` v3, then `bcp_req` var1 val1, `level`=2.
- NUM_VARIABLE=2, BCP always conflicts → requests v0=0 then v0=1, `unassign` v0, `unsat`=1, exactly 2 `bcp_req`.
- `imp_valid`(v3) and `bcp_done`+`bcp_conflict` in the same cycle → v3 pushed then popped with `unassign_var`=3 before the flip.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the SAT solver core: trail entry layout and the
// sequencing controller state encoding.
package sat_pkg;

  // Widest variable index carried in a trail entry (128 variables).
  localparam int VAR_W = 7;

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic             val;
    logic             is_decision;
    logic             flipped;
  } trail_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DECIDE     = 3'd1,
    ST_PROPAGATE  = 3'd2,
    ST_BACKTRACK  = 3'd3,
    ST_SAT_DONE   = 3'd4,
    ST_UNSAT_DONE = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/unassigned_finder.sv
// Lowest-zero priority encoder over the assigned bit-vector: reports
// whether any variable is still free and the lowest free index.
module unassigned_finder #(
  parameter int NUM_VARIABLE = 128,
  parameter int IDX_W        = 7
) (
  input  logic [NUM_VARIABLE-1:0] assigned,
  output logic                    found,
  output logic [IDX_W-1:0]        index
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_VARIABLE - 1; i >= 0; i--) begin
      if (!assigned[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/decide_backtrack_ctrl.sv
// DPLL sequencing controller: owns the assignment trail and decision level,
// issues decisions to BCP, records implications and backtracks
// chronologically on conflict until the search ends in sat or unsat.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting for start
// ST_DECIDE     | pick lowest unassigned variable, or finish as sat
// ST_PROPAGATE  | BCP running; record implications until bcp_done
// ST_BACKTRACK  | pop implications / flipped decisions, flip the first
//               | unflipped decision, or finish as unsat on empty trail
// ST_SAT_DONE   | sat held; start restarts the search
// ST_UNSAT_DONE | unsat held; start restarts the search
//
// The variable index must address NUM_VARIABLE exactly
// (NUM_VARIABLE == 2**(VARIABLE_INDEX+1)) and fit in sat_pkg::VAR_W.
module decide_backtrack_ctrl
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE   = 128,
  parameter int VARIABLE_INDEX = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    bcp_req,
  output logic [VARIABLE_INDEX:0] bcp_var,
  output logic                    bcp_val,
  input  logic                    imp_valid,
  input  logic [VARIABLE_INDEX:0] imp_var,
  input  logic                    imp_val,
  input  logic                    bcp_done,
  input  logic                    bcp_conflict,
  output logic                    unassign_valid,
  output logic [VARIABLE_INDEX:0] unassign_var,
  output logic [VARIABLE_INDEX+1:0] level,
  output logic                    busy,
  output logic                    sat,
  output logic                    unsat
);

  localparam int IW = VARIABLE_INDEX + 1;
  localparam int PW = VARIABLE_INDEX + 2;

  ctrl_state_t state, state_next;

  trail_entry_t            trail [NUM_VARIABLE];
  logic [PW-1:0]           tp;
  logic [NUM_VARIABLE-1:0] assigned;

  logic                    find_found;
  logic [IW-1:0]           find_index;

  logic [PW-1:0]           tp_dec;
  logic [IW-1:0]           tp_idx;
  logic [IW-1:0]           top_idx;
  trail_entry_t            top;
  logic [IW-1:0]           top_var;

  logic do_clear, do_push_dec, do_push_imp, do_pop, do_flip;
  logic set_sat, set_unsat;

  unassigned_finder #(
    .NUM_VARIABLE (NUM_VARIABLE),
    .IDX_W        (IW)
  ) u_finder (
    .assigned (assigned),
    .found    (find_found),
    .index    (find_index)
  );

  // Trail addressing: next free slot and current top-of-stack entry.
  always_comb begin
    tp_dec  = tp - PW'(1);
    tp_idx  = tp[IW-1:0];
    top_idx = tp_dec[IW-1:0];
    top     = trail[top_idx];
    top_var = top.var_idx[IW-1:0];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the single datapath action for this cycle.
  always_comb begin
    state_next  = state;
    do_clear    = 1'b0;
    do_push_dec = 1'b0;
    do_push_imp = 1'b0;
    do_pop      = 1'b0;
    do_flip     = 1'b0;
    set_sat     = 1'b0;
    set_unsat   = 1'b0;
    case (state)
      ST_IDLE, ST_SAT_DONE, ST_UNSAT_DONE: begin
        if (start) begin
          do_clear   = 1'b1;
          state_next = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (!find_found) begin
          set_sat    = 1'b1;
          state_next = ST_SAT_DONE;
        end else begin
          do_push_dec = 1'b1;
          state_next  = ST_PROPAGATE;
        end
      end
      ST_PROPAGATE: begin
        // Duplicate implications are dropped; this also bounds the trail.
        if (imp_valid && !assigned[imp_var]) do_push_imp = 1'b1;
        if (bcp_done) state_next = bcp_conflict ? ST_BACKTRACK : ST_DECIDE;
      end
      ST_BACKTRACK: begin
        if (tp == '0) begin
          set_unsat  = 1'b1;
          state_next = ST_UNSAT_DONE;
        end else if (!top.is_decision || top.flipped) begin
          do_pop = 1'b1;
        end else begin
          do_flip    = 1'b1;
          state_next = ST_PROPAGATE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Busy everywhere except the resting states.
  always_comb begin
    busy = !(state == ST_IDLE || state == ST_SAT_DONE || state == ST_UNSAT_DONE);
  end

  // Pointer, assigned vector, level and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tp             <= '0;
      assigned       <= '0;
      level          <= '0;
      bcp_req        <= 1'b0;
      bcp_var        <= '0;
      bcp_val        <= 1'b0;
      unassign_valid <= 1'b0;
      unassign_var   <= '0;
      sat            <= 1'b0;
      unsat          <= 1'b0;
    end else begin
      bcp_req        <= do_push_dec | do_flip;
      unassign_valid <= do_pop;
      if (do_clear) begin
        tp       <= '0;
        assigned <= '0;
        level    <= '0;
        sat      <= 1'b0;
        unsat    <= 1'b0;
      end
      if (do_push_dec) begin
        assigned[find_index] <= 1'b1;
        tp                   <= tp + PW'(1);
        level                <= level + PW'(1);
        bcp_var              <= find_index;
        bcp_val              <= 1'b0;
      end
      if (do_push_imp) begin
        assigned[imp_var] <= 1'b1;
        tp                <= tp + PW'(1);
      end
      if (do_pop) begin
        assigned[top_var] <= 1'b0;
        tp                <= tp_dec;
        unassign_var      <= top_var;
        if (top.is_decision) level <= level - PW'(1);
      end
      if (do_flip) begin
        bcp_var <= top_var;
        bcp_val <= ~top.val;
      end
      if (set_sat)   sat   <= 1'b1;
      if (set_unsat) unsat <= 1'b1;
    end
  end

  // Trail storage; entries above tp are don't-care so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push_dec) begin
      trail[tp_idx] <= '{var_idx: VAR_W'(find_index), val: 1'b0,
                         is_decision: 1'b1, flipped: 1'b0};
    end
    if (do_push_imp) begin
      trail[tp_idx] <= '{var_idx: VAR_W'(imp_var), val: imp_val,
                         is_decision: 1'b0, flipped: 1'b0};
    end
    if (do_flip) begin
      trail[top_idx].val     <= ~top.val;
      trail[top_idx].flipped <= 1'b1;
    end
  end

endmodule
